sel_mem_seq: RTL and testbench

- Sequencer for the memory-selector register: steps the 4-bit memory select code through every neuron of the encoder layer (layer 0), then the decoder layer (layer 1).
- Pulses the selector's load enable once per neuron, then starts the MAC datapath and waits for its completion before advancing.
- Sits between the top-level autoencoder control (start/done) and the selector register plus MAC engine.

---
 rtl/sel_mem_seq_pkg.sv | 20 ++
 rtl/sel_mem_seq_if.sv | 31 +++
 rtl/sel_mem_seq.sv | 112 +++++++++++
 tb/tb_sel_mem_seq.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sel_mem_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sel_mem_seq_pkg
// Description : Shared types and widths for the memory-selector sequencer.
// Revision    : 1.0
// ============================================================================
package sel_mem_seq_pkg;

  localparam int SEL_W = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEL   = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sel_mem_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : sel_mem_seq_if
// Description : Control/selector/MAC handshake bundle around the sequencer.
// Revision    : 1.0
// ============================================================================
interface sel_mem_seq_if;
  import sel_mem_seq_pkg::*;

  logic             start;
  logic             abort;
  logic             mac_done;
  logic             sel_en;
  logic [SEL_W-1:0] sel_code;
  logic             mac_start;
  logic             layer;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, mac_done,
    input  sel_en, sel_code, mac_start, layer, busy, done
  );

  modport slave (
    input  start, abort, mac_done,
    output sel_en, sel_code, mac_start, layer, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/sel_mem_seq.sv
`default_nettype none
// ============================================================================
// Module      : sel_mem_seq
// Description : Steps the selector code through layer-0 then layer-1 neurons,
//               pulsing sel_en and mac_start per neuron, awaiting mac_done.
// Revision    : 1.0
// ============================================================================
module sel_mem_seq
  import sel_mem_seq_pkg::*;
#(
  parameter int L0_NEURONS = 2,
  parameter int L1_NEURONS = 4,
  parameter int L0_BASE    = 0,
  parameter int L1_BASE    = 2
) (
  input  logic          clk,
  input  logic          rst,
  sel_mem_seq_if.slave  bus
);

  if ((L0_NEURONS < 1) || (L0_NEURONS > 16) || (L1_NEURONS < 1) || (L1_NEURONS > 16) ||
      (L0_BASE < 0) || (L1_BASE < 0) ||
      (L0_BASE + L0_NEURONS > 16) || (L1_BASE + L1_NEURONS > 16)) begin : g_param_check
    $fatal(1, "sel_mem_seq: neuron count or base code out of range");
  end

  localparam logic [SEL_W-1:0] c_l0_last = SEL_W'(L0_NEURONS - 1);
  localparam logic [SEL_W-1:0] c_l1_last = SEL_W'(L1_NEURONS - 1);
  localparam logic [SEL_W-1:0] c_l0_base = SEL_W'(L0_BASE);
  localparam logic [SEL_W-1:0] c_l1_base = SEL_W'(L1_BASE);

  state_t           r_state;
  logic             r_layer;
  logic [SEL_W-1:0] r_idx;
  logic [SEL_W-1:0] r_sel_code;

  state_t           w_state_nxt;
  logic             w_layer_nxt;
  logic [SEL_W-1:0] w_idx_nxt;
  logic [SEL_W-1:0] w_last;
  logic [SEL_W-1:0] w_code_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_layer    <= 1'b0;
      r_idx      <= '0;
      r_sel_code <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_layer <= w_layer_nxt;
      r_idx   <= w_idx_nxt;
      // Code is latched on SEL entry so it is already valid during SEL itself.
      if (w_state_nxt == SEL) begin
        r_sel_code <= w_code_nxt;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_layer_nxt = r_layer;
    w_idx_nxt   = r_idx;
    w_last      = r_layer ? c_l1_last : c_l0_last;

    case (r_state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          w_state_nxt = SEL;
          w_layer_nxt = 1'b0;
          w_idx_nxt   = '0;
        end
      end
      SEL:   w_state_nxt = ISSUE;
      ISSUE: w_state_nxt = WAIT;
      WAIT: begin
        if (bus.mac_done) begin
          if (r_idx < w_last) begin
            w_idx_nxt   = r_idx + 1'b1;
            w_state_nxt = SEL;
          end else if (!r_layer) begin
            w_layer_nxt = 1'b1;
            w_idx_nxt   = '0;
            w_state_nxt = SEL;
          end else begin
            w_state_nxt = DONE;
          end
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    // Cancel wins over any progress; layer/idx are left where they were.
    if (bus.abort && (r_state != IDLE)) begin
      w_state_nxt = IDLE;
      w_layer_nxt = r_layer;
      w_idx_nxt   = r_idx;
    end

    w_code_nxt = (w_layer_nxt ? c_l1_base : c_l0_base) + w_idx_nxt;
  end

  assign bus.sel_en    = (r_state == SEL);
  assign bus.mac_start = (r_state == ISSUE);
  assign bus.done      = (r_state == DONE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.layer     = r_layer;
  assign bus.sel_code  = r_sel_code;

endmodule
`default_nettype wire

// File: tb/tb_sel_mem_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_sel_mem_seq
// Description : Directed self-checking bench for the selector sequencer.
// Revision    : 1.0
// ============================================================================
module tb_sel_mem_seq;
  import sel_mem_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sel_mem_seq_if bus();
  sel_mem_seq_if bus2();

  logic md_resp;
  logic md_force;
  assign bus.mac_done = md_resp | md_force;

  sel_mem_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  sel_mem_seq #(
    .L0_NEURONS (1),
    .L1_NEURONS (1),
    .L0_BASE    (0),
    .L1_BASE    (15)
  ) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int codes[$];
  int lays[$];
  int n_mst, n_done, first_sel, done_cyc;
  int hold_code = -1;
  int hold_len  = 0;
  int wcnt      = -1;

  int exp_codes[6] = '{0, 1, 2, 3, 4, 5};
  int exp_lays[6]  = '{0, 0, 1, 1, 1, 1};
  int e2_se[7]     = '{1, 0, 0, 1, 0, 0, 0};
  int e2_ms[7]     = '{0, 1, 0, 0, 1, 0, 0};
  int e2_dn[7]     = '{0, 0, 0, 0, 0, 0, 1};
  int e2_code[7]   = '{0, 0, 0, 15, 15, 15, 15};
  int e2_lay[7]    = '{0, 0, 0, 1, 1, 1, 1};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Event log of the main DUT, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (bus.sel_en) begin
      if (codes.size() == 0) first_sel = cyc;
      codes.push_back(int'(bus.sel_code));
      lays.push_back(int'(bus.layer));
    end
    if (bus.mac_start) n_mst++;
    if (bus.done) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  // MAC model: answers in the first WAIT cycle, or hold_len cycles later for hold_code.
  always @(negedge clk) begin
    md_resp = 1'b0;
    if (rst) wcnt = -1;
    else if (bus.mac_start) wcnt = (int'(bus.sel_code) == hold_code) ? hold_len : 0;
    else if (wcnt == 0) begin
      md_resp = 1'b1;
      wcnt    = -1;
    end else if (wcnt > 0) wcnt--;
  end

  task automatic clr();
    codes.delete();
    lays.delete();
    n_mst     = 0;
    n_done    = 0;
    first_sel = -1;
    done_cyc  = -1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string tag);
    int k;
    k = 0;
    while (!bus.done && k < bound) begin
      @(negedge clk);
      k++;
    end
    #1;
    chk({tag, "_timeout"}, k < bound, 1);
  endtask

  task automatic check_pass(input string tag, input int exp_len);
    chk({tag, "_nsel"}, codes.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("%s_code%0d", tag, i), (i < codes.size()) ? codes[i] : -1, exp_codes[i]);
      chk($sformatf("%s_lay%0d", tag, i), (i < lays.size()) ? lays[i] : -1, exp_lays[i]);
    end
    chk({tag, "_nmst"}, n_mst, 6);
    chk({tag, "_ndone"}, n_done, 1);
    chk({tag, "_len"}, done_cyc - first_sel, exp_len);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    md_force     = 1'b0;
    bus2.start   = 1'b0;
    bus2.abort   = 1'b0;
    bus2.mac_done = 1'b0;
    clr();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_sel_en", bus.sel_en, 0);
    chk("rst_sel_code", bus.sel_code, 0);
    chk("rst_mac_start", bus.mac_start, 0);
    chk("rst_layer", bus.layer, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    rst = 1'b0;

    // Full pass, immediate mac_done: SEL..DONE spans 19 cycles.
    clr();
    pulse_start();
    wait_done(100, "p1");
    check_pass("p1", 18);
    @(negedge clk);
    #1;
    chk("p1_busy_after", bus.busy, 0);
    chk("p1_code_hold", bus.sel_code, 5);
    chk("p1_layer_hold", bus.layer, 1);

    // Neuron 1 held 10 extra cycles; stray mac_done in SEL and start while busy.
    clr();
    hold_code = 1;
    hold_len  = 10;
    pulse_start();
    md_force = 1'b1;
    @(negedge clk);
    md_force = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("p2_hold_code", bus.sel_code, 1);
    chk("p2_hold_busy", bus.busy, 1);
    chk("p2_hold_nmst", n_mst, 2);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(100, "p2");
    check_pass("p2", 28);
    hold_code = -1;
    @(negedge clk);

    // abort beats start in IDLE, abort alone in IDLE does nothing.
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    #1;
    chk("idle_abort_start_busy", bus.busy, 0);
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    #1;
    chk("idle_abort_busy", bus.busy, 0);

    // Abort in layer 1, idx 2 (code 4).
    clr();
    pulse_start();
    k = 0;
    while (!(bus.sel_en && bus.sel_code == 4'd4) && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("ab_reach_timeout", k < 50, 1);
    chk("ab_layer", bus.layer, 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    #1;
    chk("ab_busy", bus.busy, 0);
    chk("ab_sel_en", bus.sel_en, 0);
    chk("ab_mac_start", bus.mac_start, 0);
    chk("ab_done", bus.done, 0);
    repeat (10) @(negedge clk);
    chk("ab_no_done", n_done, 0);
    clr();
    pulse_start();
    #1;
    chk("rs_sel_en", bus.sel_en, 1);
    chk("rs_code", bus.sel_code, 0);
    chk("rs_layer", bus.layer, 0);
    wait_done(100, "rs");
    check_pass("rs", 18);
    @(negedge clk);

    // Async reset asserted between edges while waiting on code 3.
    clr();
    hold_code = 3;
    hold_len  = 20;
    pulse_start();
    k = 0;
    while (!(bus.mac_start && bus.sel_code == 4'd3) && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("ar_reach_timeout", k < 50, 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_busy", bus.busy, 0);
    chk("ar_code", bus.sel_code, 0);
    chk("ar_layer", bus.layer, 0);
    chk("ar_sel_en", bus.sel_en, 0);
    chk("ar_mac_start", bus.mac_start, 0);
    chk("ar_done", bus.done, 0);
    @(negedge clk);
    rst = 1'b0;
    hold_code = -1;
    repeat (3) @(negedge clk);
    #1;
    chk("ar_idle_busy", bus.busy, 0);
    chk("ar_no_done", n_done, 0);

    // Minimal config: codes 0 then 15, mac_done held high throughout.
    bus2.mac_done = 1'b1;
    @(negedge clk);
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk($sformatf("m%0d_sel_en", i), bus2.sel_en, e2_se[i]);
      chk($sformatf("m%0d_mac_start", i), bus2.mac_start, e2_ms[i]);
      chk($sformatf("m%0d_done", i), bus2.done, e2_dn[i]);
      chk($sformatf("m%0d_code", i), bus2.sel_code, e2_code[i]);
      chk($sformatf("m%0d_layer", i), bus2.layer, e2_lay[i]);
    end
    @(negedge clk);
    #1;
    chk("m_busy_after", bus2.busy, 0);
    bus2.mac_done = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
